// File: rtl/joypad_reader.sv
// joypad_reader: host-side reader for a latched serial controller port
// (4021-style parallel-in/serial-out). On a start request it strobes the
// controller, clocks out NBITS-1 further bits with an active-low shift clock,
// samples the active-low serial line into a shadow register and commits the
// whole snapshot to data in a single DONE cycle.
//
// Ports:
//   CLK        in   single clock, rising edge
//   nRES       in   asynchronous active-low reset
//   start      in   read request, sampled only in IDLE
//   sdata_in   in   serial data from controller, 0 = pressed
//   strobe_out out  parallel-load strobe to controller
//   n_clk_out  out  shift clock to controller, active low
//   busy       out  read in progress (through the DONE cycle)
//   done       out  one-cycle pulse, data just updated
//   data       out  last completed snapshot, 1 = pressed
module joypad_reader #(
  parameter int NBITS  = 8,
  parameter int STROBE = 2,
  parameter int DIV    = 4
) (
  input  logic             CLK,
  input  logic             nRES,
  input  logic             start,
  input  logic             sdata_in,
  output logic             strobe_out,
  output logic             n_clk_out,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] data
);

  localparam int PMAX = (DIV > STROBE) ? DIV : STROBE;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int BW   = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STRB, S_SETTLE, S_CLKLO, S_CLKHI, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_phase, w_phase_nxt;
  logic [BW-1:0]    r_bit, w_bit_nxt;
  logic [NBITS-1:0] r_shadow, w_shadow_nxt;
  logic [NBITS-1:0] r_data;
  logic             r_strobe, r_nclk, r_busy, r_done;
  logic             w_last, w_commit;
  logic [NBITS:0]   w_cat;

  // Phase counter is loaded with length-1 on entry and counts down to 0.
  assign w_last = (r_phase == '0);

  // Bits arrive LSB first; shifting in at the top leaves the first sample
  // in bit 0 once all NBITS samples have been taken. Works for NBITS=1 too.
  assign w_cat = {~sdata_in, r_shadow};

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = w_last ? r_phase : r_phase - PW'(1);
    w_bit_nxt    = r_bit;
    w_shadow_nxt = r_shadow;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_STRB;
          w_phase_nxt = PW'(STROBE - 1);
          w_bit_nxt   = '0;
        end
      end
      S_STRB: begin
        if (w_last) begin
          w_state_nxt = S_SETTLE;
          w_phase_nxt = PW'(DIV - 1);
        end
      end
      S_SETTLE: begin
        if (w_last) begin
          w_shadow_nxt = w_cat[NBITS:1];
          w_bit_nxt    = BW'(1);
          if (NBITS == 1) begin
            w_state_nxt = S_DONE;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_CLKLO;
            w_phase_nxt = PW'(DIV - 1);
          end
        end
      end
      S_CLKLO: begin
        if (w_last) begin
          w_state_nxt = S_CLKHI;
          w_phase_nxt = PW'(DIV - 1);
        end
      end
      S_CLKHI: begin
        if (w_last) begin
          w_shadow_nxt = w_cat[NBITS:1];
          w_bit_nxt    = r_bit + BW'(1);
          // r_bit counts samples already taken; this one is the last
          if (r_bit == BW'(NBITS - 1)) begin
            w_state_nxt = S_DONE;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_CLKLO;
            w_phase_nxt = PW'(DIV - 1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state into flops so the pins are
  // glitch-free and aligned with the state they belong to.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_bit    <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_strobe <= 1'b0;
      r_nclk   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_bit    <= w_bit_nxt;
      r_shadow <= w_shadow_nxt;
      r_strobe <= (w_state_nxt == S_STRB);
      r_nclk   <= (w_state_nxt != S_CLKLO);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
      // Commit uses the merged shadow so the final bit lands in DONE too
      if (w_commit) r_data <= w_shadow_nxt;
    end
  end

  assign strobe_out = r_strobe;
  assign n_clk_out  = r_nclk;
  assign busy       = r_busy;
  assign done       = r_done;
  assign data       = r_data;

endmodule

// File: tb/tb_joypad_reader.sv
module tb_joypad_reader;
  localparam int NB  = 8;
  localparam int ST  = 2;
  localparam int DV  = 4;
  localparam int LAT = 1 + ST + DV + 2 * DV * (NB - 1);

  logic CLK = 1'b0, nRES = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic strb0, nclk0, busy0, done0, sdata0;
  logic [NB-1:0] data0;
  logic strb1, nclk1, busy1, done1;
  logic [0:0] data1;
  logic sdata1 = 1'b0;
  int n_cmp = 0, n_bad = 0;

  always #5 CLK = ~CLK;

  joypad_reader #(.NBITS(NB), .STROBE(ST), .DIV(DV)) u0 (
    .CLK(CLK), .nRES(nRES), .start(start0), .sdata_in(sdata0),
    .strobe_out(strb0), .n_clk_out(nclk0), .busy(busy0), .done(done0), .data(data0));

  joypad_reader #(.NBITS(1), .STROBE(1), .DIV(1)) u1 (
    .CLK(CLK), .nRES(nRES), .start(start1), .sdata_in(sdata1),
    .strobe_out(strb1), .n_clk_out(nclk1), .busy(busy1), .done(done1), .data(data1));

  // Controller model: strobe high loads (output follows button 0), every
  // rising shift clock advances to the next button; beyond NB reads released.
  logic [NB-1:0] pressed = '0;
  int m_cnt = 0;
  always @(posedge nclk0 or posedge strb0)
    if (strb0) m_cnt <= 0;
    else       m_cnt <= m_cnt + 1;
  assign sdata0 = (m_cnt < NB) ? ~pressed[m_cnt[2:0]] : 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Global properties sampled every cycle on both instances
  logic pd0 = 1'b0, pd1 = 1'b0, pr = 1'b0;
  logic [NB-1:0] pdat0 = '0;
  logic [0:0] pdat1 = '0;
  always @(negedge CLK) begin
    n_cmp++;
    assert (!(strb0 && !nclk0) && !(strb1 && !nclk1)) else begin
      n_bad++; $error("FAIL overlap: strb %b%b nclk %b%b expected no strobe with clk low", strb0, strb1, nclk0, nclk1);
    end
    if (nRES && pr) begin
      n_cmp++;
      assert (!(done0 && pd0) && !(done1 && pd1)) else begin
        n_bad++; $error("FAIL done_pulse: done %b%b prev %b%b expected single-cycle", done0, done1, pd0, pd1);
      end
      n_cmp++;
      assert ((done0 || data0 === pdat0) && (done1 || data1 === pdat1)) else begin
        n_bad++; $error("FAIL data_stable: data %h/%h prev %h/%h expected unchanged without done", data0, data1, pdat0, pdat1);
      end
    end
    pd0 <= done0; pd1 <= done1; pdat0 <= data0; pdat1 <= data1; pr <= nRES;
  end

  // Per-cycle record of u0; cycle c is the period ending at edge c (edge 0 = start seen)
  logic rs[0:199], rn[0:199], rd[0:199], rb[0:199];
  logic [NB-1:0] rdat[0:199];
  int s_ndone, s_fdone, s_ldone, s_nstrb, s_fstrb, s_nlow, s_flow, s_badlen, s_nbusylo;
  logic [NB-1:0] s_datf, s_datl, s_datpre;

  task automatic record(input int n, input bit hold, input int p1, input int p2,
                        input bit pa_en, input logic [NB-1:0] pa_val);
    for (int c = 1; c <= n; c++) begin
      @(posedge CLK); @(negedge CLK);
      rs[c] = strb0; rn[c] = nclk0; rd[c] = done0; rb[c] = busy0; rdat[c] = data0;
      if (done0 && pa_en) pressed = pa_val;
      start0 = hold || (c == p1) || (c == p2);
    end
  endtask

  task automatic summarize(input int n);
    int run;
    run = 0; s_ndone = 0; s_fdone = -1; s_ldone = -1; s_nstrb = 0; s_fstrb = -1;
    s_nlow = 0; s_flow = -1; s_badlen = 0; s_nbusylo = 0; s_datf = 'x; s_datl = 'x;
    for (int c = 1; c <= n; c++) begin
      if (rd[c]) begin
        s_ndone++;
        if (s_fdone < 0) begin s_fdone = c; s_datf = rdat[c]; end
        s_ldone = c; s_datl = rdat[c];
      end
      if (rs[c]) begin s_nstrb++; if (s_fstrb < 0) s_fstrb = c; end
      if (!rn[c]) begin
        if (run == 0) begin s_nlow++; if (s_flow < 0) s_flow = c; end
        run++;
      end else begin
        if (run != 0 && run != DV) s_badlen++;
        run = 0;
      end
    end
    if (run != 0) s_badlen++;
    s_datpre = (s_fdone > 1) ? rdat[s_fdone-1] : 'x;
    for (int c = 1; c < s_ldone; c++) if (!rb[c]) s_nbusylo++;
  endtask

  // One isolated read over a 70-cycle window, checked against spec timing
  task automatic check_single(input string tag, input logic [NB-1:0] exp_val,
                              input logic [NB-1:0] old_val);
    summarize(70);
    chk({tag, ".ndone"},  s_ndone, 1);
    chk({tag, ".lat"},    s_fdone, LAT);
    chk({tag, ".data"},   s_datf, exp_val);
    chk({tag, ".hold"},   s_datpre, old_val);
    chk({tag, ".nstrb"},  s_nstrb, ST);
    chk({tag, ".fstrb"},  s_fstrb, 1);
    chk({tag, ".nlow"},   s_nlow, NB - 1);
    chk({tag, ".flow"},   s_flow, 1 + ST + DV);
    chk({tag, ".lowlen"}, s_badlen, 0);
    chk({tag, ".busy"},   s_nbusylo, 0);
    chk({tag, ".busyend"}, {rb[LAT], rb[LAT+1]}, 2'b10);
  endtask

  initial begin
    logic [NB-1:0] old, v;
    int p, d1c, low1, strb1c;
    logic [0:0] d1v;

    // Reset state
    #1 nRES = 1'b0;
    #1;
    chk("rst.strobe", strb0, 0);
    chk("rst.nclk",   nclk0, 1);
    chk("rst.busy",   busy0, 0);
    chk("rst.done",   done0, 0);
    chk("rst.data",   data0, 0);
    @(negedge CLK); @(negedge CLK);
    nRES = 1'b1;
    @(negedge CLK);

    // Reset mid-CLKLO of bit 3 (cycles 23..26): outputs drop at once, nothing committed
    pressed = 8'h3C;
    start0 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    start0 = 1'b0;
    repeat (23) @(negedge CLK);
    chk("abort.inlow", nclk0, 0);
    #2 nRES = 1'b0;
    #1;
    chk("abort.strobe", strb0, 0);
    chk("abort.nclk",   nclk0, 1);
    chk("abort.busy",   busy0, 0);
    chk("abort.data",   data0, 0);
    @(negedge CLK); nRES = 1'b1; @(negedge CLK);

    // Directed read of 8'hA5
    pressed = 8'hA5;
    start0 = 1'b1;
    record(70, 1'b0, -1, -1, 1'b0, '0);
    check_single("a5", 8'hA5, 8'h00);

    // Two back-to-back reads with start held high: 00 then FF
    pressed = 8'h00;
    start0 = 1'b1;
    record(130, 1'b1, -1, -1, 1'b1, 8'hFF);
    start0 = 1'b0;
    summarize(130);
    chk("b2b.ndone",  s_ndone, 2);
    chk("b2b.first",  s_fdone, LAT);
    chk("b2b.second", s_ldone, 2 * LAT + 1);
    chk("b2b.data0",  s_datf, 8'h00);
    chk("b2b.data1",  s_datl, 8'hFF);
    chk("b2b.busylo", s_nbusylo, 1);
    chk("b2b.nlow",   s_nlow, 2 * (NB - 1));
    chk("b2b.lowlen", s_badlen, 0);
    repeat (70) @(negedge CLK);

    // start pulses during a read (incl. DONE cycle) are ignored
    pressed = 8'($urandom);
    v = pressed;
    start0 = 1'b1;
    record(70, 1'b0, 10, LAT, 1'b0, '0);
    check_single("ign", v, 8'hFF);
    old = v;

    // Minimal configuration on u1: NBITS=1, STROBE=1, DIV=1, line held at 0
    d1c = -1; low1 = 0; strb1c = 0; d1v = 'x;
    start1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge CLK); @(negedge CLK);
      start1 = 1'b0;
      if (done1 && d1c < 0) begin d1c = c; d1v = data1; end
      if (!nclk1) low1++;
      if (strb1) strb1c++;
    end
    chk("n1.done",  d1c, 3);
    chk("n1.data",  d1v, 1'b1);
    chk("n1.nlow",  low1, 0);
    chk("n1.nstrb", strb1c, 1);

    // Randomized reads with a stray start pulse somewhere mid-read
    for (int i = 0; i < 4; i++) begin
      pressed = 8'($urandom);
      v = pressed;
      p = $urandom_range(5, LAT);
      start0 = 1'b1;
      record(70, 1'b0, p, -1, 1'b0, '0);
      check_single($sformatf("rnd%0d", i), v, old);
      old = v;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
